wb_cmd_master: RTL and testbench

- Single-outstanding Wishbone classic initiator that converts a valid/ready command stream into bus cycles and returns a response stream.
- Drives Wishbone slaves such as the team's single- and dual-port RAMs and register blocks.
- Used by debug bridges and test harnesses that need bus access without a CPU.
- One transfer per command, no bursts, no automatic retry; has a bus-timeout watchdog.

---
 rtl/wb_cmd_master_if.sv | 48 ++++
 rtl/wb_cmd_master.sv | 135 +++++++++++++
 tb/tb_wb_cmd_master.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_if.sv
// Command/response stream plus Wishbone classic bus for wb_cmd_master.
// Streams use valid/ready: a transfer happens at the edge where both are high; valid holds its payload stable until then.
interface wb_cmd_master_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data;
  logic [SELECT_WIDTH-1:0] cmd_sel;
  logic                    cmd_we;
  logic                    cmd_valid;
  logic                    cmd_ready;

  logic [DATA_WIDTH-1:0]   rsp_data;
  logic [1:0]              rsp_status;
  logic                    rsp_valid;
  logic                    rsp_ready;

  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic                    wb_we_o;
  logic [SELECT_WIDTH-1:0] wb_sel_o;
  logic                    wb_stb_o;
  logic                    wb_ack_i;
  logic                    wb_err_i;
  logic                    wb_rty_i;
  logic                    wb_cyc_o;

  modport master (
    input  cmd_addr, cmd_data, cmd_sel, cmd_we, cmd_valid,
    output cmd_ready,
    output rsp_data, rsp_status, rsp_valid,
    input  rsp_ready,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    output cmd_addr, cmd_data, cmd_sel, cmd_we, cmd_valid,
    input  cmd_ready,
    input  rsp_data, rsp_status, rsp_valid,
    output rsp_ready,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator: one bus cycle per command,
// one response per bus cycle, with a watchdog that forces termination.
module wb_cmd_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic            clk,
  input  logic            rst,
  wb_cmd_master_if.master bus,
  output logic [1:0]      dbg_state
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_ERR = 2'd1;
  localparam logic [1:0] ST_RTY = 2'd2;
  localparam logic [1:0] ST_TMO = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic                    cmd_ready_q;
  logic                    cyc_q;
  logic                    stb_q;
  logic                    we_q;
  logic [SELECT_WIDTH-1:0] sel_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic [1:0]              rsp_status_q;
  logic [CNT_W-1:0]        tmo_cnt;

  logic                    tmo_hit;
  logic                    term_hit;
  logic [1:0]              term_status;
  logic [DATA_WIDTH-1:0]   term_data;

  assign tmo_hit = (TIMEOUT > 0) && (tmo_cnt == CNT_LAST);

  // Slave terminations outrank the watchdog when both land on the same edge.
  always_comb begin
    term_hit    = 1'b1;
    term_status = ST_OK;
    term_data   = '0;
    if (bus.wb_err_i) begin
      term_status = ST_ERR;
    end else if (bus.wb_rty_i) begin
      term_status = ST_RTY;
    end else if (bus.wb_ack_i) begin
      term_data = we_q ? '0 : bus.wb_dat_i;
    end else if (tmo_hit) begin
      term_status = ST_TMO;
    end else begin
      term_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_ready_q  <= 1'b1;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      tmo_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            adr_q       <= bus.cmd_addr;
            dat_q       <= bus.cmd_data;
            we_q        <= bus.cmd_we;
            sel_q       <= bus.cmd_sel;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            tmo_cnt     <= '0;
            cmd_ready_q <= 1'b0;
            state       <= BUS;
          end
        end
        BUS: begin
          // adr/dat are left holding the last access; only control drops.
          if (term_hit) begin
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= term_data;
            rsp_status_q <= term_status;
            state        <= RESP;
          end else if (TIMEOUT > 0) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.wb_cyc_o   = cyc_q;
  assign bus.wb_stb_o   = stb_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_sel_o   = sel_q;
  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = dat_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_status = rsp_status_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: behavioural RAM slave with selectable termination,
// randomized commands, and a scoreboard fed by a transaction-level model.
module tb_wb_cmd_master;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int SW  = 4;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  wb_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) bus ();

  wb_cmd_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          we;
    int            cyc_len;
  } bus_exp_t;

  logic [DW-1:0] exp_q[$];
  logic [1:0]    exp_st_q[$];
  bus_exp_t      exp_bus_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] slv_mem [256];

  // slave modes: 0 ack, 1 err, 2 rty, 3 silent
  int slv_mode = 0;
  int slv_lat  = 1;
  int slv_age  = 0;
  bit spur_en    = 1'b0;
  bit rdy_random = 1'b0;
  bit mon_en     = 1'b1;
  int hold_cnt   = 0;

  logic          hold_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic [1:0]    held_st;
  logic          prev_cyc = 1'b0;
  int            cyc_len  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Transaction-level expectation: terminating edge is lat+1 after acceptance
  // unless that falls beyond the watchdog window.
  task automatic send_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input logic we, input int mode, input int lat, input bit track);
    logic [DW-1:0] ed;
    logic [1:0]    es;
    int            clen;
    bit            got;
    bus_exp_t      be;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    bus.cmd_sel   = s;
    bus.cmd_we    = we;
    bus.cmd_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = bus.cmd_ready;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready stayed 0, required 1 within 300 cycles");
      bus.cmd_valid = 1'b0;
      return;
    end
    slv_mode = mode;
    slv_lat  = lat;
    if (track) begin
      if (mode == 3 || lat + 1 > TMO) begin
        es = 2'd3;
        clen = TMO;
      end else begin
        es = 2'(mode);
        clen = lat + 1;
      end
      ed = '0;
      if (es == 2'd0) begin
        if (we) ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, s);
        else    ed = ref_mem[a[7:0]];
      end
      exp_q.push_back(ed);
      exp_st_q.push_back(es);
      be.adr = a; be.dat = d; be.sel = s; be.we = we; be.cyc_len = clen;
      exp_bus_q.push_back(be);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
      exp_st_q.delete();
      exp_bus_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Registered-ack slave: decides its termination lines just after each edge.
  initial begin : slave
    logic [DW-1:0] mask;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_rty_i = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      bus.wb_rty_i = 1'b0;
      bus.wb_dat_i = $urandom;
      if (bus.wb_cyc_o && bus.wb_stb_o) begin
        if (slv_age >= slv_lat && slv_mode != 3) begin
          case (slv_mode)
            0: begin
              bus.wb_ack_i = 1'b1;
              if (bus.wb_we_o) begin
                for (int b = 0; b < SW; b++) mask[8*b +: 8] = {8{bus.wb_sel_o[b]}};
                slv_mem[bus.wb_adr_o[7:0]] = (slv_mem[bus.wb_adr_o[7:0]] & ~mask) | (bus.wb_dat_o & mask);
              end else begin
                bus.wb_dat_i = slv_mem[bus.wb_adr_o[7:0]];
              end
            end
            1: begin
              bus.wb_err_i = 1'b1;
              bus.wb_ack_i = 1'($urandom);
              bus.wb_rty_i = 1'($urandom);
            end
            default: begin
              bus.wb_rty_i = 1'b1;
              bus.wb_ack_i = 1'($urandom);
            end
          endcase
        end
        slv_age++;
      end else begin
        slv_age = 0;
        if (spur_en) begin
          bus.wb_ack_i = 1'($urandom);
          bus.wb_err_i = 1'($urandom);
          bus.wb_rty_i = 1'($urandom);
        end
      end
    end
  end

  initial begin : rsp_ready_drv
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0 && bus.rsp_valid) begin
        bus.rsp_ready = 1'b0;
        hold_cnt--;
      end else if (rdy_random) begin
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.rsp_ready = 1'b1;
      end
    end
  end

  initial begin : rsp_mon
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        hold_prev = 1'b0;
      end else if (bus.rsp_valid) begin
        check("rsp_no_cyc", 64'(bus.wb_cyc_o), 64'd0);
        if (hold_prev) begin
          check("rsp_data_stable", 64'(bus.rsp_data), 64'(held_data));
          check("rsp_status_stable", 64'(bus.rsp_status), 64'(held_st));
        end
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_unexpected: status %0d data 0x%0h, required no response", bus.rsp_status, bus.rsp_data);
          end else begin
            check("rsp_data", 64'(bus.rsp_data), 64'(exp_q.pop_front()));
            check("rsp_status", 64'(bus.rsp_status), 64'(exp_st_q.pop_front()));
          end
          hold_prev = 1'b0;
        end else begin
          hold_prev = 1'b1;
          held_data = bus.rsp_data;
          held_st   = bus.rsp_status;
        end
      end else begin
        if (hold_prev) check("rsp_valid_held", 64'(bus.rsp_valid), 64'd1);
        hold_prev = 1'b0;
      end
    end
  end

  initial begin : bus_mon
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        cyc_len  = 0;
        prev_cyc = 1'b0;
      end else begin
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'(!(bus.wb_cyc_o || bus.rsp_valid)));
        if (bus.wb_cyc_o) begin
          cyc_len++;
          if (exp_bus_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_unexpected: cyc high with no command outstanding");
          end else begin
            check("stb", 64'(bus.wb_stb_o), 64'd1);
            check("adr", 64'(bus.wb_adr_o), 64'(exp_bus_q[0].adr));
            check("dat_o", 64'(bus.wb_dat_o), 64'(exp_bus_q[0].dat));
            check("we", 64'(bus.wb_we_o), 64'(exp_bus_q[0].we));
            check("sel", 64'(bus.wb_sel_o), 64'(exp_bus_q[0].sel));
          end
        end else if (prev_cyc) begin
          if (exp_bus_q.size() != 0) begin
            check("cyc_len", 64'(cyc_len), 64'(exp_bus_q[0].cyc_len));
            void'(exp_bus_q.pop_front());
          end
          check("rsp_at_cyc_fall", 64'(bus.rsp_valid), 64'd1);
          check("stb_drop", 64'(bus.wb_stb_o), 64'd0);
          cyc_len = 0;
        end
        prev_cyc = bus.wb_cyc_o;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "global timeout");
  end

  initial begin : main
    int r;
    int mode;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.cmd_sel   = '0;
    bus.cmd_we    = 1'b0;
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("rst_stb", 64'(bus.wb_stb_o), 64'd0);
    check("rst_we", 64'(bus.wb_we_o), 64'd0);
    check("rst_sel", 64'(bus.wb_sel_o), 64'd0);
    check("rst_adr", 64'(bus.wb_adr_o), 64'd0);
    check("rst_dat", 64'(bus.wb_dat_o), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("rst_rsp_status", 64'(bus.rsp_status), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // write then read back, registered-ack latency
    send_cmd(16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 0, 1, 1'b1);
    send_cmd(16'h0010, 32'h0, 4'hF, 1'b0, 0, 1, 1'b1);
    // byte selects over a zero word
    send_cmd(16'h0020, 32'h11223344, 4'b0101, 1'b1, 0, 1, 1'b1);
    send_cmd(16'h0020, 32'h0, 4'hF, 1'b0, 0, 1, 1'b1);
    // err together with ack, then retry
    send_cmd(16'h0010, 32'h0, 4'hF, 1'b0, 1, 1, 1'b1);
    send_cmd(16'h0010, 32'h0, 4'hF, 1'b0, 2, 2, 1'b1);
    // silent slave, then a normal access
    send_cmd(16'h0030, 32'h0, 4'hF, 1'b0, 3, 1, 1'b1);
    send_cmd(16'h0010, 32'h0, 4'hF, 1'b0, 0, 1, 1'b1);
    // ack on the watchdog edge wins; one cycle later loses
    send_cmd(16'h0040, 32'hCAFEF00D, 4'hF, 1'b1, 0, 7, 1'b1);
    send_cmd(16'h0040, 32'h0, 4'hF, 1'b0, 0, 8, 1'b1);
    send_cmd(16'h0040, 32'h0, 4'hF, 1'b0, 0, 7, 1'b1);
    drain();

    // response backpressure with the next command already waiting
    hold_cnt = 5;
    send_cmd(16'h0010, 32'h0, 4'hF, 1'b0, 0, 1, 1'b1);
    send_cmd(16'h0050, 32'h5A5A5A5A, 4'hF, 1'b1, 0, 1, 1'b1);
    drain();

    spur_en    = 1'b1;
    rdy_random = 1'b1;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      mode = (r < 60) ? 0 : (r < 75) ? 1 : (r < 85) ? 2 : 3;
      send_cmd({8'($urandom), 8'($urandom_range(0, 15))}, $urandom, 4'($urandom),
               1'($urandom), mode, $urandom_range(1, 9), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    spur_en    = 1'b0;
    rdy_random = 1'b0;
    drain();

    // reset pulse while a bus cycle is open
    mon_en = 1'b0;
    send_cmd(16'h0060, 32'h0, 4'hF, 1'b0, 3, 1, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_cyc", 64'(bus.wb_cyc_o), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("mid_rst_stb", 64'(bus.wb_stb_o), 64'd0);
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
      check("post_rst_no_cyc", 64'(bus.wb_cyc_o), 64'd0);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send_cmd(16'h0070, 32'h89ABCDEF, 4'hF, 1'b1, 0, 1, 1'b1);
    send_cmd(16'h0070, 32'h0, 4'hF, 1'b0, 0, 1, 1'b1);
    drain();

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("exp_bus_q_empty", 64'(exp_bus_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
